// File: rtl/rx_link_pkg.sv
// rtl/rx_link_pkg.sv - shared state encoding and counter width for the rx link buffer
package rx_link_pkg;

  localparam int CRD_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_STOP       = 2'd0,
    ST_ACTIVATE   = 2'd1,
    ST_RUN        = 2'd2,
    ST_DEACTIVATE = 2'd3
  } rx_link_state_e;

endpackage

// File: rtl/rx_flit_fifo.sv
// rtl/rx_flit_fifo.sv - DEPTH x FLIT_W flit store with wrap-around pointers and occupancy
module rx_flit_fifo
  import rx_link_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [FLIT_W-1:0]    wdata,
  input  logic                 pop,
  output logic [FLIT_W-1:0]    rdata,
  output logic [CRD_CNT_W-1:0] occupancy,
  output logic                 empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [FLIT_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CRD_CNT_W-1:0] count_q, count_d;
  logic                 do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pop only real entries; a push on a full store is allowed only alongside a pop.
  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CRD_CNT_W'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CRD_CNT_W'(do_push) - CRD_CNT_W'(do_pop);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; emptiness is tracked by count_q.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign occupancy = count_q;
  assign empty     = (count_q == '0);

endmodule

// File: rtl/rx_link_buffer.sv
// rtl/rx_link_buffer.sv - credit-based receive link buffer; optional RX_LINK_BUF_BYPASS_EN same-cycle bypass
module rx_link_buffer
  import rx_link_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int FLIT_W = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 link_active_req,
  output logic                 link_active_ack,
  input  logic                 flitv,
  input  logic [FLIT_W-1:0]    flit,
  input  logic                 crd_rtn,
  output logic                 lcrdv,
  output logic                 out_valid,
  output logic [FLIT_W-1:0]    out_flit,
  input  logic                 out_ready,
  output logic [CRD_CNT_W-1:0] crd_outstanding,
  output logic                 overflow_err
);

  localparam logic [CRD_CNT_W:0] DEPTH_SUM = (CRD_CNT_W + 1)'(DEPTH);

  rx_link_state_e       state_q, state_d;
  logic                 ack_q, ack_d;
  logic                 lcrdv_q, lcrdv_d;
  logic                 ovf_q, ovf_d;
  logic [CRD_CNT_W-1:0] crd_q, crd_d;

  logic [CRD_CNT_W-1:0] occ;
  logic                 fifo_empty;
  logic [FLIT_W-1:0]    fifo_rdata;
  logic                 flit_acc, rtn_acc, push, pop;
  logic [CRD_CNT_W:0]   slot_sum;

  // Credit accounting: a grant is counted in the same edge it is driven out,
  // so the occupancy+credits sum never lets more slots be promised than exist.
  always_comb begin
    flit_acc = flitv && (crd_q != '0);
    rtn_acc  = crd_rtn && (state_q == ST_DEACTIVATE) && (crd_q > CRD_CNT_W'(flit_acc));
    slot_sum = {1'b0, occ} + {1'b0, crd_q};
    lcrdv_d  = (state_q == ST_RUN) && link_active_req && (slot_sum < DEPTH_SUM);
    crd_d    = crd_q + CRD_CNT_W'(lcrdv_d) - CRD_CNT_W'(flit_acc) - CRD_CNT_W'(rtn_acc);
    ovf_d    = ovf_q | (flitv && !flit_acc) | (crd_rtn && !rtn_acc);
  end

  // Link state machine; a reactivation request in DEACTIVATE waits for STOP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP:       if (link_active_req) state_d = ST_ACTIVATE;
      ST_ACTIVATE:   state_d = ST_RUN;
      ST_RUN:        if (!link_active_req) state_d = ST_DEACTIVATE;
      ST_DEACTIVATE: if ((crd_q == '0) && !crd_rtn && !flitv) state_d = ST_STOP;
      default:       state_d = ST_STOP;
    endcase
    ack_d = (state_d == ST_RUN) || (state_d == ST_DEACTIVATE);
  end

  // Downstream path; draining continues regardless of link state.
  always_comb begin
`ifdef RX_LINK_BUF_BYPASS_EN
    push      = flit_acc && !(fifo_empty && out_ready);
    out_valid = !fifo_empty || flit_acc;
    out_flit  = fifo_empty ? flit : fifo_rdata;
    pop       = !fifo_empty && out_ready;
`else
    push      = flit_acc;
    out_valid = !fifo_empty;
    out_flit  = fifo_rdata;
    pop       = !fifo_empty && out_ready;
`endif
  end

  // Control registers; reset discards credits immediately with no pulses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_STOP;
      ack_q   <= 1'b0;
      lcrdv_q <= 1'b0;
      ovf_q   <= 1'b0;
      crd_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      lcrdv_q <= lcrdv_d;
      ovf_q   <= ovf_d;
      crd_q   <= crd_d;
    end
  end

  rx_flit_fifo #(
    .DEPTH  (DEPTH),
    .FLIT_W (FLIT_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .wdata     (flit),
    .pop       (pop),
    .rdata     (fifo_rdata),
    .occupancy (occ),
    .empty     (fifo_empty)
  );

  assign link_active_ack = ack_q;
  assign lcrdv           = lcrdv_q;
  assign crd_outstanding = crd_q;
  assign overflow_err    = ovf_q;

endmodule

// File: tb/tb_rx_link_buffer.sv
// tb/tb_rx_link_buffer.sv - self-checking bench for rx_link_buffer
module tb_rx_link_buffer;

  localparam int DEPTH  = 4;
  localparam int FLIT_W = 64;

  logic              clock = 1'b0;
  logic              reset;
  logic              link_active_req;
  logic              link_active_ack;
  logic              flitv;
  logic [FLIT_W-1:0] flit;
  logic              crd_rtn;
  logic              lcrdv;
  logic              out_valid;
  logic [FLIT_W-1:0] out_flit;
  logic              out_ready;
  logic [3:0]        crd_outstanding;
  logic              overflow_err;

  rx_link_buffer #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
    .clock           (clock),
    .reset           (reset),
    .link_active_req (link_active_req),
    .link_active_ack (link_active_ack),
    .flitv           (flitv),
    .flit            (flit),
    .crd_rtn         (crd_rtn),
    .lcrdv           (lcrdv),
    .out_valid       (out_valid),
    .out_flit        (out_flit),
    .out_ready       (out_ready),
    .crd_outstanding (crd_outstanding),
    .overflow_err    (overflow_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int credits = 0;
  logic [FLIT_W-1:0] q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive, let the edge happen, update the upstream/downstream model, compare.
  task automatic cyc(input logic fv, input logic [FLIT_W-1:0] d, input logic rdy);
    logic pop_now, push_now;
    pop_now   = rdy && (q.size() != 0);
    push_now  = fv && (credits > 0);
    flitv     = fv;
    flit      = d;
    out_ready = rdy;
    @(posedge clock); #1;
    flitv     = 1'b0;
    out_ready = 1'b0;
    if (lcrdv === 1'b1) credits++;
    if (pop_now) void'(q.pop_front());
    if (push_now) begin
      q.push_back(d);
      credits--;
    end
    chk("crd_outstanding", 64'(crd_outstanding), 64'(credits));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (q.size() != 0) chk("out_flit", out_flit, q[0]);
  endtask

  task automatic rtn(input bit legal);
    crd_rtn = 1'b1;
    @(posedge clock); #1;
    crd_rtn = 1'b0;
    if (lcrdv === 1'b1) credits++;
    if (legal) credits--;
    chk("crd_after_rtn", 64'(crd_outstanding), 64'(credits));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    link_active_req = 1'b0;
    flitv = 1'b0;
    crd_rtn = 1'b0;
    out_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    q.delete();
    credits = 0;
  endtask

  initial begin
    logic [5:0] pat;
    logic [2:0] pat3;
    int         nl;

    reset = 1'b1; link_active_req = 1'b0; flitv = 1'b0; flit = '0;
    crd_rtn = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ack", 64'(link_active_ack), 64'd0);
    chk("rst_lcrdv", 64'(lcrdv), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_crd", 64'(crd_outstanding), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);

    // Activation: ack two cycles after request, then four back-to-back grants.
    reset = 1'b0;
    link_active_req = 1'b1;
    cyc(1'b0, '0, 1'b0);
    chk("ack_after_1", 64'(link_active_ack), 64'd0);
    cyc(1'b0, '0, 1'b0);
    chk("ack_after_2", 64'(link_active_ack), 64'd1);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, '0, 1'b0);
      pat[i] = lcrdv;
    end
    chk("grant_pattern", 64'(pat), 64'b001111);
    chk("crd_full", 64'(crd_outstanding), 64'd4);

    // Fill with out_ready low: no further grants; one pop yields exactly one grant.
    for (int i = 0; i < 4; i++) cyc(1'b1, {$urandom, $urandom}, 1'b0);
    nl = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b0);
      nl += int'(lcrdv);
    end
    chk("no_grant_when_full", 64'(nl), 64'd0);
    cyc(1'b0, '0, 1'b1);
    pat3[0] = lcrdv;
    cyc(1'b0, '0, 1'b0);
    pat3[1] = lcrdv;
    cyc(1'b0, '0, 1'b0);
    pat3[2] = lcrdv;
    chk("regrant_after_pop", 64'(pat3), 64'b010);

    // Use the last credit, then an uncredited flit: dropped, sticky error.
    cyc(1'b1, {$urandom, $urandom}, 1'b0);
    chk("ovf_before_drop", 64'(overflow_err), 64'd0);
    cyc(1'b1, 64'hDEAD_BEEF_0BAD_F00D, 1'b0);
    chk("ovf_on_drop", 64'(overflow_err), 64'd1);
    nl = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b0);
      nl += int'(lcrdv);
    end
    chk("ovf_sticky", 64'(overflow_err), 64'd1);
    chk("no_grant_after_drop", 64'(nl), 64'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1);
    chk("drained_four_only", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b0);
    chk("crd_refilled", 64'(crd_outstanding), 64'd4);

    // Deactivate with two outstanding credits, return them, reach STOP.
    cyc(1'b1, {$urandom, $urandom}, 1'b0);
    cyc(1'b1, {$urandom, $urandom}, 1'b0);
    chk("crd_two", 64'(crd_outstanding), 64'd2);
    link_active_req = 1'b0;
    nl = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b0);
      nl += int'(lcrdv);
    end
    chk("no_grant_deact", 64'(nl), 64'd0);
    chk("ack_in_deact", 64'(link_active_ack), 64'd1);
    rtn(1'b1);
    rtn(1'b1);
    chk("ack_after_returns", 64'(link_active_ack), 64'd1);
    cyc(1'b0, '0, 1'b0);
    chk("ack_stop", 64'(link_active_ack), 64'd0);
    nl = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1);
      nl += int'(lcrdv);
    end
    chk("no_grant_stop", 64'(nl), 64'd0);
    chk("ovf_still_set", 64'(overflow_err), 64'd1);

    // Mid-operation reset with three flits buffered.
    link_active_req = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0);
    chk("crd_react", 64'(crd_outstanding), 64'd4);
    for (int i = 0; i < 3; i++) cyc(1'b1, {$urandom, $urandom}, 1'b0);
    reset = 1'b1;
    link_active_req = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_crd", 64'(crd_outstanding), 64'd0);
    chk("async_rst_ack", 64'(link_active_ack), 64'd0);
    chk("async_rst_ovf", 64'(overflow_err), 64'd0);
    @(posedge clock); #1;
    chk("rst_edge_lcrdv", 64'(lcrdv), 64'd0);
    chk("rst_edge_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    q.delete();
    credits = 0;
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0);

    // Credit return outside DEACTIVATE is an error and changes nothing.
    rtn(1'b0);
    chk("rtn_in_stop_ovf", 64'(overflow_err), 64'd1);
    do_reset();
    chk("ovf_cleared", 64'(overflow_err), 64'd0);

    // Streaming with out_ready held high: order A..D, at most one flit buffered.
    link_active_req = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b0);
    chk("crd_stream", 64'(crd_outstanding), 64'd4);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 64'hA + 64'(k), 1'b1);
      chk("stream_depth", 64'(q.size()), 64'd1);
    end
    cyc(1'b0, '0, 1'b1);
    chk("stream_empty", 64'(out_valid), 64'd0);

    // Randomised traffic against the queue/credit model.
    for (int i = 0; i < 400; i++) begin
      logic fv, rdy;
      fv  = (credits > 0) && ($urandom_range(0, 1) == 1);
      rdy = ($urandom_range(0, 3) != 0);
      cyc(fv, {$urandom, $urandom}, rdy);
    end
    chk("random_no_ovf", 64'(overflow_err), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_link_buffer.md
RX_LINK_BUFFER -- requirements
Module: rx_link_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning flit slots and maximum credits granted (2..8).
REQ-002 SHALL have parameter FLIT_W, default 64, meaning flit width in bits.
REQ-003 SHALL have port clock  input  1  sole clock; all state on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port link_active_req  input  1  upstream request to activate (1) or deactivate (0) the link.
REQ-006 SHALL have port link_active_ack  output  1  link-active acknowledge.
REQ-007 SHALL have port flitv  input  1  incoming flit valid; each pulse consumes one granted credit.
REQ-008 SHALL have port flit  input  FLIT_W  incoming flit payload.
REQ-009 SHALL have port crd_rtn  input  1  upstream returns one unused credit; legal only in DEACTIVATE.
REQ-010 SHALL have port lcrdv  output  1  one-cycle credit grant pulse to upstream.
REQ-011 SHALL have port out_valid  output  1  buffered flit available downstream.
REQ-012 SHALL have port out_flit  output  FLIT_W  head flit.
REQ-013 SHALL have port out_ready  input  1  downstream accepts; pop when out_valid and out_ready are both 1.
REQ-014 SHALL have port crd_outstanding  output  4  credits granted and not yet consumed or returned.
REQ-015 SHALL have port overflow_err  output  1  sticky; set by flitv arriving with crd_outstanding equal to 0.

Function
REQ-016 SHALL implement FSM STOP, ACTIVATE, RUN, DEACTIVATE with registered state.
REQ-017 SHALL move STOP->ACTIVATE on link_active_req=1, ACTIVATE->RUN on the next cycle, RUN->DEACTIVATE on link_active_req=0, and DEACTIVATE->STOP when crd_outstanding=0 and no crd_rtn or flitv occurs that cycle.
REQ-018 SHALL drive link_active_ack=1 as a registered output in RUN and DEACTIVATE, and 0 otherwise.
REQ-019 SHALL assert lcrdv, registered, in a cycle only when state=RUN and occupancy+crd_outstanding<DEPTH (both registered), at most one grant per cycle.
REQ-020 SHALL compute crd_outstanding next as current + lcrdv - flitv(accepted) - crd_rtn; simultaneous grant and consume SHALL leave it unchanged.
REQ-021 SHALL write an accepted flitv into the FIFO tail; out_valid for it SHALL rise the following cycle (latency 1).
REQ-022 SHALL, on a pop, free the slot next cycle; the earliest regrant for that slot SHALL be one cycle after the pop.
REQ-023 SHALL perform a simultaneous push and pop on a full FIFO without loss or stall, and on an empty FIFO as push only.
REQ-024 SHALL drop any flitv arriving with crd_outstanding=0, set overflow_err, and leave counts unchanged.
REQ-025 SHALL ignore crd_rtn arriving outside DEACTIVATE or with crd_outstanding=0, and set overflow_err.
REQ-026 SHALL continue downstream draining in every state; DEACTIVATE only suppresses new grants.
REQ-027 SHALL, if link_active_req rises in DEACTIVATE, complete to STOP before reactivating.

Reset
REQ-028 SHALL, on reset, set state=STOP, lcrdv=0, link_active_ack=0, out_valid=0, crd_outstanding=0, overflow_err=0, and FIFO empty; out_flit SHALL be don't-care.
REQ-029 SHALL, on reset asserted mid-operation, discard buffered flits and outstanding credits immediately with no credit pulses.

Configuration
REQ-030 SHALL, with RX_LINK_BUF_BYPASS_EN defined, present an arriving flit combinationally on out_valid/out_flit in the same cycle when the FIFO is empty; if out_ready=1 it SHALL not be written and SHALL count as consumed-and-freed, otherwise it SHALL be stored.
REQ-031 SHALL, without RX_LINK_BUF_BYPASS_EN, keep latency fixed at 1 cycle per REQ-021.

Structure
REQ-032 SHALL take the FSM state enum (rx_link_state_e) and constant CRD_CNT_W=4 from shared package rx_link_pkg.
REQ-033 SHALL place storage in one sub-module rx_flit_fifo (DEPTH x FLIT_W, wrap-around pointers, occupancy output).

Verification (DEPTH=4)
REQ-034 SHALL cover: req=1 after reset -> ack=1 two cycles later; lcrdv pulses 4 consecutive cycles; crd_outstanding=4.
REQ-035 SHALL cover: 4 flits sent with out_ready=0 -> out_valid=1, zero further lcrdv; one pop -> exactly one lcrdv the cycle after.
REQ-036 SHALL cover: 5th flitv with crd_outstanding=0 -> flit dropped, overflow_err=1 and sticky, occupancy stays 4.
REQ-037 SHALL cover: RUN with outstanding=2, req=0 -> no lcrdv; two crd_rtn pulses -> state=STOP, ack=0.
REQ-038 SHALL cover: out_ready=1 steady, back-to-back flits 0xA..0xD -> output order A,B,C,D; occupancy never exceeds 1 (0 with bypass, same-cycle out_valid).
REQ-039 SHALL cover: reset pulsed with 3 flits buffered -> all outputs at reset values next edge, no lcrdv.
